regfile_ctl: RTL and testbench

Sequencer and write-port arbiter for the triple-port register file (16 × 32 bits). The write port shares its address with read port 0.
- After reset, it clears all 16 registers to zero, since the LUT RAM has no reset.
- It then shares port 0 (write address plus the dout0 read) among three requesters: the core, the load-writeback unit and the debug port.
- Read ports 1 and 2 belong to the core and pass straight through.
- It sits between the RISC core and the register file instance.

---
 rtl/regfile_pkg.sv | 10 +
 rtl/regfile_ctl_if.sv | 33 +++
 rtl/regfile_wr_arb.sv | 45 ++++
 rtl/regfile_ctl.sv | 98 +++++++++
 tb/tb_regfile_ctl.sv | 324 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared sizes and enumerations for the register-file sequencer and
// port-0 arbiter.
package regfile_pkg;
  localparam int NREG   = 16;
  localparam int RNO_W  = 4;
  localparam int DATA_W = 32;

  typedef enum logic {CLEAR, RUN} state_t;
  typedef enum logic [1:0] {OWN_CORE, OWN_LD, OWN_DBG, OWN_NONE} owner_t;
endpackage

// File: rtl/regfile_ctl_if.sv
// Core, load-writeback, debug and register-file signals of regfile_ctl.
// The master side is the surrounding system; the slave side is the controller.
interface regfile_ctl_if;
  import regfile_pkg::*;

  logic [RNO_W-1:0]  core_rno0, core_rno1, core_rno2;
  logic              core_use0, core_wr, core_stall;
  logic [DATA_W-1:0] core_din;
  logic              ld_valid, ld_ready;
  logic [RNO_W-1:0]  ld_rno;
  logic [DATA_W-1:0] ld_data;
  logic              dbg_req, dbg_we, dbg_ack;
  logic [RNO_W-1:0]  dbg_rno;
  logic [DATA_W-1:0] dbg_wdata, dbg_rdata;
  logic [RNO_W-1:0]  rf_rno0, rf_rno1, rf_rno2;
  logic [DATA_W-1:0] rf_din, rf_dout0;
  logic              rf_wr;
  logic              ready;

  modport master (
    output core_rno0, core_rno1, core_rno2, core_use0, core_wr, core_din,
    output ld_valid, ld_rno, ld_data, dbg_req, dbg_we, dbg_rno, dbg_wdata, rf_dout0,
    input  core_stall, ld_ready, dbg_ack, dbg_rdata,
    input  rf_rno0, rf_rno1, rf_rno2, rf_din, rf_wr, ready
  );

  modport slave (
    input  core_rno0, core_rno1, core_rno2, core_use0, core_wr, core_din,
    input  ld_valid, ld_rno, ld_data, dbg_req, dbg_we, dbg_rno, dbg_wdata, rf_dout0,
    output core_stall, ld_ready, dbg_ack, dbg_rdata,
    output rf_rno0, rf_rno1, rf_rno2, rf_din, rf_wr, ready
  );
endinterface

// File: rtl/regfile_wr_arb.sv
// Combinational port-0 owner selection with a saturating load-starvation
// counter that lets a refused load force its way in.
module regfile_wr_arb
  import regfile_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   run,
  input  logic   core_req,
  input  logic   ld_valid,
  input  logic   dbg_req,
  output owner_t owner
);
  logic [3:0] starve_reg, starve_next;
  logic       force_ld;

  always_comb begin
    force_ld = ld_valid && (starve_reg == 4'(STARVE_MAX));
    owner    = OWN_NONE;
    if (run) begin
      if (force_ld)      owner = OWN_LD;
      else if (core_req) owner = OWN_CORE;
      else if (ld_valid) owner = OWN_LD;
      else if (dbg_req)  owner = OWN_DBG;
    end
  end

  // Every granted load is a transfer, so the counter restarts on any load grant.
  always_comb begin
    starve_next = starve_reg;
    if (run && ld_valid) begin
      if (owner == OWN_LD)
        starve_next = 4'd0;
      else if (starve_reg != 4'(STARVE_MAX))
        starve_next = starve_reg + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_reg <= 4'd0;
    else     starve_reg <= starve_next;
  end
endmodule

// File: rtl/regfile_ctl.sv
// Register-file sequencer: zero-fills all registers after reset, then
// arbitrates port 0 among core, load writeback and debug.
module regfile_ctl
  import regfile_pkg::*;
#(
  parameter int STARVE_MAX = 4
) (
  input logic          clk,
  input logic          rst,
  regfile_ctl_if.slave bus
);
  state_t            state_reg, state_next;
  logic [RNO_W-1:0]  cnt_reg, cnt_next;
  logic              dbg_ack_reg;
  logic [DATA_W-1:0] dbg_rdata_reg;
  owner_t            owner;
  logic              run, core_req, dbg_req_eff;
  logic [RNO_W-1:0]  rno0;
  logic [DATA_W-1:0] din;
  logic              wr, stall;

  assign run         = (state_reg == RUN);
  assign core_req    = bus.core_use0 || bus.core_wr;
  // A request still held during its own ack cycle must not start a second access.
  assign dbg_req_eff = bus.dbg_req && !dbg_ack_reg;

  regfile_wr_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .core_req (core_req),
    .ld_valid (bus.ld_valid),
    .dbg_req  (dbg_req_eff),
    .owner    (owner)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    if (state_reg == CLEAR) begin
      cnt_next = cnt_reg + 1'b1;
      if (cnt_reg == RNO_W'(NREG - 1)) state_next = RUN;
    end
  end

  always_comb begin
    rno0  = bus.core_rno0;
    din   = bus.core_din;
    wr    = 1'b0;
    stall = core_req && (owner != OWN_CORE);
    case (owner)
      OWN_CORE: wr = bus.core_wr;
      OWN_LD: begin
        rno0 = bus.ld_rno;
        din  = bus.ld_data;
        wr   = 1'b1;
      end
      OWN_DBG: begin
        rno0 = bus.dbg_rno;
        din  = bus.dbg_wdata;
        wr   = bus.dbg_we;
      end
      default: ;
    endcase
    // No clear write may be issued while reset is still asserted.
    if (state_reg == CLEAR) begin
      rno0  = cnt_reg;
      din   = '0;
      wr    = !rst;
      stall = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= CLEAR;
      cnt_reg       <= '0;
      dbg_ack_reg   <= 1'b0;
      dbg_rdata_reg <= '0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      dbg_ack_reg <= (owner == OWN_DBG);
      if (owner == OWN_DBG) dbg_rdata_reg <= bus.rf_dout0;
    end
  end

  assign bus.rf_rno0    = rno0;
  assign bus.rf_rno1    = bus.core_rno1;
  assign bus.rf_rno2    = bus.core_rno2;
  assign bus.rf_din     = din;
  assign bus.rf_wr      = wr;
  assign bus.core_stall = stall;
  assign bus.ld_ready   = (owner == OWN_LD);
  assign bus.dbg_ack    = dbg_ack_reg;
  assign bus.dbg_rdata  = dbg_rdata_reg;
  assign bus.ready      = run;
endmodule

// File: tb/tb_regfile_ctl.sv
// Bench for regfile_ctl: a behavioural register file on port 0, directed
// scenarios, then randomized traffic against a priority-rule reference model.
module tb_regfile_ctl;
  import regfile_pkg::*;

  localparam int SM = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic scramble = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [31:0] rf_mem [16];

  regfile_ctl_if bus();

  regfile_ctl #(.STARVE_MAX(SM)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  // Register-file stand-in: asynchronous read, write on the rising edge.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 32'hBAD0_0000 | 32'(i);
    end else if (bus.rf_wr) begin
      rf_mem[bus.rf_rno0] <= bus.rf_din;
    end
  end
  assign bus.rf_dout0 = rf_mem[bus.rf_rno0];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.core_rno0 = 4'd0; bus.core_rno1 = 4'd0; bus.core_rno2 = 4'd0;
    bus.core_use0 = 1'b0; bus.core_wr = 1'b0; bus.core_din = 32'd0;
    bus.ld_valid = 1'b0; bus.ld_rno = 4'd0; bus.ld_data = 32'd0;
    bus.dbg_req = 1'b0; bus.dbg_we = 1'b0; bus.dbg_rno = 4'd0; bus.dbg_wdata = 32'd0;
  endtask

  // Reset, release, and follow the 16-write clear sequence into RUN.
  task automatic reset_and_clear(input string tag);
    rst = 1'b1;
    set_idle();
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      #1;
      checks++; if (bus.rf_wr !== 1'b1) begin errors++; $display("FAIL %s_clear_wr k=%0d: got %b expected 1", tag, k, bus.rf_wr); end
      checks++; if (bus.rf_rno0 !== k[3:0]) begin errors++; $display("FAIL %s_clear_rno0: got %0d expected %0d", tag, bus.rf_rno0, k); end
      checks++; if (bus.rf_din !== 32'd0) begin errors++; $display("FAIL %s_clear_din k=%0d: got %h expected 0", tag, k, bus.rf_din); end
      checks++; if (bus.core_stall !== 1'b1) begin errors++; $display("FAIL %s_clear_stall k=%0d: got %b expected 1", tag, k, bus.core_stall); end
      checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL %s_clear_ready k=%0d: got %b expected 0", tag, k, bus.ready); end
      tick();
    end
    #1;
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL %s_ready: got %b expected 1", tag, bus.ready); end
    checks++; if (bus.core_stall !== 1'b0) begin errors++; $display("FAIL %s_run_stall: got %b expected 0", tag, bus.core_stall); end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rf_mem[i] !== 32'd0) begin errors++; $display("FAIL %s_zero r%0d: got %h expected 0", tag, i, rf_mem[i]); end
    end
    $display("%s: clear sequence complete", tag);
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    scramble = 1'b1;
    set_idle();
    tick();
    scramble = 1'b0;
    bus.ld_valid = 1'b1;
    bus.dbg_req = 1'b1;
    tick();
    #1;
    checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("FAIL reset_rf_wr: got %b expected 0", bus.rf_wr); end
    checks++; if (bus.core_stall !== 1'b1) begin errors++; $display("FAIL reset_stall: got %b expected 1", bus.core_stall); end
    checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL reset_ld_ready: got %b expected 0", bus.ld_ready); end
    checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL reset_dbg_ack: got %b expected 0", bus.dbg_ack); end
    checks++; if (bus.dbg_rdata !== 32'd0) begin errors++; $display("FAIL reset_dbg_rdata: got %h expected 0", bus.dbg_rdata); end
    checks++; if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", bus.ready); end
    $display("reset: outputs held");
    reset_and_clear("reset");
  endtask

  // Core writes r5 while a load waits three cycles, then the idle core lets it in.
  task automatic test_core_write();
    set_idle();
    bus.core_wr = 1'b1; bus.core_rno0 = 4'd5; bus.core_din = 32'hDEADBEEF;
    bus.ld_valid = 1'b1; bus.ld_rno = 4'd3; bus.ld_data = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.ld_ready !== 1'b0) begin errors++; $display("FAIL core_ld_ready c%0d: got %b expected 0", i, bus.ld_ready); end
      checks++; if (bus.core_stall !== 1'b0) begin errors++; $display("FAIL core_stall c%0d: got %b expected 0", i, bus.core_stall); end
      checks++; if (bus.rf_wr !== 1'b1 || bus.rf_rno0 !== 4'd5) begin errors++; $display("FAIL core_wr c%0d: got wr=%b rno=%0d expected wr=1 rno=5", i, bus.rf_wr, bus.rf_rno0); end
      tick();
    end
    checks++; if (rf_mem[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL core_r5: got %h expected deadbeef", rf_mem[5]); end
    $display("core: wrote r5 = deadbeef");
    bus.core_wr = 1'b0;
    #1;
    checks++; if (bus.ld_ready !== 1'b1 || bus.rf_rno0 !== 4'd3) begin errors++; $display("FAIL core_ld_after: got rdy=%b rno=%0d expected rdy=1 rno=3", bus.ld_ready, bus.rf_rno0); end
    tick();
    checks++; if (rf_mem[3] !== 32'h11111111) begin errors++; $display("FAIL core_ld_r3: got %h expected 11111111", rf_mem[3]); end
    $display("core: load wrote r3 = 11111111");
    set_idle();
  endtask

  task automatic test_starve();
    set_idle();
    bus.core_use0 = 1'b1; bus.core_rno0 = 4'd2;
    bus.ld_valid = 1'b1; bus.ld_rno = 4'd3; bus.ld_data = 32'h12345678;
    for (int i = 1; i <= 5; i++) begin
      #1;
      checks++; if (bus.ld_ready !== (i == 5)) begin errors++; $display("FAIL starve_ld_ready c%0d: got %b expected %b", i, bus.ld_ready, (i == 5)); end
      checks++; if (bus.core_stall !== (i == 5)) begin errors++; $display("FAIL starve_stall c%0d: got %b expected %b", i, bus.core_stall, (i == 5)); end
      if (i == 5) begin
        checks++; if (bus.rf_wr !== 1'b1 || bus.rf_rno0 !== 4'd3) begin errors++; $display("FAIL starve_force: got wr=%b rno=%0d expected wr=1 rno=3", bus.rf_wr, bus.rf_rno0); end
      end
      tick();
    end
    checks++; if (rf_mem[3] !== 32'h12345678) begin errors++; $display("FAIL starve_r3: got %h expected 12345678", rf_mem[3]); end
    $display("starve: forced load wrote r3 = 12345678");
    set_idle();
  endtask

  // The forced cycle drops the core write; the core retries it afterwards.
  task automatic test_force_core_wr();
    set_idle();
    bus.core_wr = 1'b1; bus.core_rno0 = 4'd6;
    bus.ld_valid = 1'b1; bus.ld_rno = 4'd4; bus.ld_data = 32'h44444444;
    for (int i = 1; i <= 5; i++) begin
      bus.core_din = 32'hC0DE0000 + 32'(i);
      #1;
      checks++; if (bus.core_stall !== (i == 5)) begin errors++; $display("FAIL force_stall c%0d: got %b expected %b", i, bus.core_stall, (i == 5)); end
      checks++; if (bus.rf_rno0 !== ((i == 5) ? 4'd4 : 4'd6)) begin errors++; $display("FAIL force_rno0 c%0d: got %0d expected %0d", i, bus.rf_rno0, (i == 5) ? 4 : 6); end
      tick();
    end
    checks++; if (rf_mem[6] !== 32'hC0DE0004) begin errors++; $display("FAIL force_r6: got %h expected c0de0004", rf_mem[6]); end
    checks++; if (rf_mem[4] !== 32'h44444444) begin errors++; $display("FAIL force_r4: got %h expected 44444444", rf_mem[4]); end
    bus.ld_valid = 1'b0;
    bus.core_din = 32'hC0DE0005;
    #1;
    checks++; if (bus.core_stall !== 1'b0 || bus.rf_wr !== 1'b1) begin errors++; $display("FAIL force_retry: got stall=%b wr=%b expected stall=0 wr=1", bus.core_stall, bus.rf_wr); end
    tick();
    checks++; if (rf_mem[6] !== 32'hC0DE0005) begin errors++; $display("FAIL force_retry_r6: got %h expected c0de0005", rf_mem[6]); end
    $display("force: core retry wrote r6 = c0de0005");
    set_idle();
  endtask

  task automatic test_debug();
    set_idle();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b1; bus.dbg_rno = 4'd7; bus.dbg_wdata = 32'hA5A5A5A5;
    #1;
    checks++; if (bus.rf_wr !== 1'b1 || bus.rf_rno0 !== 4'd7 || bus.rf_din !== 32'hA5A5A5A5) begin errors++; $display("FAIL dbgw_grant: got wr=%b rno=%0d din=%h expected 1 7 a5a5a5a5", bus.rf_wr, bus.rf_rno0, bus.rf_din); end
    checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL dbgw_early_ack: got %b expected 0", bus.dbg_ack); end
    tick();
    #1;
    checks++; if (bus.dbg_ack !== 1'b1) begin errors++; $display("FAIL dbgw_ack: got %b expected 1", bus.dbg_ack); end
    checks++; if (bus.dbg_rdata !== 32'd0) begin errors++; $display("FAIL dbgw_old: got %h expected 0", bus.dbg_rdata); end
    checks++; if (bus.rf_wr !== 1'b0) begin errors++; $display("FAIL dbgw_ignored: got %b expected 0", bus.rf_wr); end
    tick();
    bus.dbg_req = 1'b0;
    #1;
    checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL dbgw_pulse: got %b expected 0", bus.dbg_ack); end
    checks++; if (rf_mem[7] !== 32'hA5A5A5A5) begin errors++; $display("FAIL dbgw_r7: got %h expected a5a5a5a5", rf_mem[7]); end
    $display("debug: write r7 = a5a5a5a5, old = %h", bus.dbg_rdata);
    tick();
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_rno = 4'd7;
    #1;
    checks++; if (bus.rf_wr !== 1'b0 || bus.rf_rno0 !== 4'd7) begin errors++; $display("FAIL dbgr_grant: got wr=%b rno=%0d expected 0 7", bus.rf_wr, bus.rf_rno0); end
    tick();
    bus.dbg_req = 1'b0;
    #1;
    checks++; if (bus.dbg_ack !== 1'b1) begin errors++; $display("FAIL dbgr_ack: got %b expected 1", bus.dbg_ack); end
    checks++; if (bus.dbg_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL dbgr_data: got %h expected a5a5a5a5", bus.dbg_rdata); end
    tick();
    #1;
    checks++; if (bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL dbgr_pulse: got %b expected 0", bus.dbg_ack); end
    checks++; if (bus.dbg_rdata !== 32'hA5A5A5A5) begin errors++; $display("FAIL dbgr_hold: got %h expected a5a5a5a5", bus.dbg_rdata); end
    $display("debug: read r7 = %h", bus.dbg_rdata);
    tick();
  endtask

  // Load and debug collide; the load wins and debug follows, reading the new value.
  task automatic test_back_to_back();
    set_idle();
    bus.ld_valid = 1'b1; bus.ld_rno = 4'd9; bus.ld_data = 32'h99887766;
    bus.dbg_req = 1'b1; bus.dbg_we = 1'b0; bus.dbg_rno = 4'd9;
    #1;
    checks++; if (bus.ld_ready !== 1'b1 || bus.rf_rno0 !== 4'd9) begin errors++; $display("FAIL b2b_ld: got rdy=%b rno=%0d expected 1 9", bus.ld_ready, bus.rf_rno0); end
    tick();
    bus.ld_valid = 1'b0;
    #1;
    checks++; if (bus.rf_wr !== 1'b0 || bus.rf_rno0 !== 4'd9 || bus.dbg_ack !== 1'b0) begin errors++; $display("FAIL b2b_dbg_grant: got wr=%b rno=%0d ack=%b expected 0 9 0", bus.rf_wr, bus.rf_rno0, bus.dbg_ack); end
    tick();
    bus.dbg_req = 1'b0;
    #1;
    checks++; if (bus.dbg_ack !== 1'b1 || bus.dbg_rdata !== 32'h99887766) begin errors++; $display("FAIL b2b_dbg_data: got ack=%b data=%h expected 1 99887766", bus.dbg_ack, bus.dbg_rdata); end
    $display("b2b: load r9 then debug read %h", bus.dbg_rdata);
    tick();
  endtask

  task automatic test_reset_mid_clear();
    set_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      #1;
      checks++; if (bus.rf_rno0 !== k[3:0]) begin errors++; $display("FAIL midclr_first_rno0: got %0d expected %0d", bus.rf_rno0, k); end
      tick();
    end
    bus.ld_valid = 1'b1; bus.dbg_req = 1'b1;
    rst = 1'b1;
    #1;
    checks++; if (bus.rf_wr !== 1'b0 || bus.core_stall !== 1'b1 || bus.ready !== 1'b0) begin errors++; $display("FAIL midclr_abort: got wr=%b stall=%b ready=%b expected 0 1 0", bus.rf_wr, bus.core_stall, bus.ready); end
    $display("midclr: reset at clear step 9");
    reset_and_clear("midclr");
  endtask

  task automatic test_random();
    logic [31:0] mref [16];
    int          mstarve;
    logic        mack, next_ack;
    logic [31:0] mrdata;
    logic        ld_pend, dbg_pend, force_m, core_req, exp_wr, exp_stall;
    owner_t      mo;
    logic [3:0]  exp_rno;
    logic [31:0] exp_din;
    int          a;
    reset_and_clear("rand");
    for (int i = 0; i < 16; i++) mref[i] = 32'd0;
    mstarve = 0; mack = 1'b0; mrdata = 32'd0; ld_pend = 1'b0; dbg_pend = 1'b0;
    for (int c = 0; c < 400; c++) begin
      bus.core_use0 = ($urandom_range(0, 3) == 0);
      bus.core_wr   = ($urandom_range(0, 3) == 0);
      bus.core_rno0 = 4'($urandom_range(0, 15));
      bus.core_rno1 = 4'($urandom_range(0, 15));
      bus.core_rno2 = 4'($urandom_range(0, 15));
      bus.core_din  = $urandom;
      if (!ld_pend && $urandom_range(0, 2) == 0) begin
        ld_pend = 1'b1; bus.ld_rno = 4'($urandom_range(0, 15)); bus.ld_data = $urandom;
      end
      if (!dbg_pend && $urandom_range(0, 4) == 0) begin
        dbg_pend = 1'b1; bus.dbg_we = 1'($urandom_range(0, 1));
        bus.dbg_rno = 4'($urandom_range(0, 15)); bus.dbg_wdata = $urandom;
      end
      bus.ld_valid = ld_pend;
      bus.dbg_req  = dbg_pend;
      // Reference: forced load, then core, then load, then debug (not in its ack cycle).
      core_req = bus.core_use0 || bus.core_wr;
      force_m  = ld_pend && (mstarve == SM);
      if (force_m) mo = OWN_LD;
      else if (core_req) mo = OWN_CORE;
      else if (ld_pend) mo = OWN_LD;
      else if (dbg_pend && !mack) mo = OWN_DBG;
      else mo = OWN_NONE;
      exp_wr    = (mo == OWN_CORE && bus.core_wr) || (mo == OWN_LD) || (mo == OWN_DBG && bus.dbg_we);
      exp_stall = core_req && (mo != OWN_CORE);
      exp_rno   = (mo == OWN_LD) ? bus.ld_rno : (mo == OWN_DBG) ? bus.dbg_rno : bus.core_rno0;
      exp_din   = (mo == OWN_LD) ? bus.ld_data : (mo == OWN_DBG) ? bus.dbg_wdata : bus.core_din;
      #1;
      checks++; if (bus.ld_ready !== (mo == OWN_LD)) begin errors++; $display("FAIL rand_ld_ready c%0d: got %b expected %b", c, bus.ld_ready, (mo == OWN_LD)); end
      checks++; if (bus.core_stall !== exp_stall) begin errors++; $display("FAIL rand_stall c%0d: got %b expected %b", c, bus.core_stall, exp_stall); end
      checks++; if (bus.rf_wr !== exp_wr) begin errors++; $display("FAIL rand_rf_wr c%0d: got %b expected %b", c, bus.rf_wr, exp_wr); end
      if (mo != OWN_NONE) begin
        checks++; if (bus.rf_rno0 !== exp_rno) begin errors++; $display("FAIL rand_rno0 c%0d: got %0d expected %0d", c, bus.rf_rno0, exp_rno); end
      end
      if (exp_wr) begin
        checks++; if (bus.rf_din !== exp_din) begin errors++; $display("FAIL rand_din c%0d: got %h expected %h", c, bus.rf_din, exp_din); end
      end
      checks++; if (bus.rf_rno1 !== bus.core_rno1 || bus.rf_rno2 !== bus.core_rno2) begin errors++; $display("FAIL rand_rno12 c%0d: got %0d/%0d expected %0d/%0d", c, bus.rf_rno1, bus.rf_rno2, bus.core_rno1, bus.core_rno2); end
      checks++; if (bus.dbg_ack !== mack) begin errors++; $display("FAIL rand_dbg_ack c%0d: got %b expected %b", c, bus.dbg_ack, mack); end
      checks++; if (bus.dbg_rdata !== mrdata) begin errors++; $display("FAIL rand_dbg_rdata c%0d: got %h expected %h", c, bus.dbg_rdata, mrdata); end
      next_ack = 1'b0;
      if (mo == OWN_DBG) begin
        mrdata = mref[bus.dbg_rno];
        next_ack = 1'b1;
        $display("rand c%0d: debug %s r%0d", c, bus.dbg_we ? "write" : "read", bus.dbg_rno);
      end
      if (mack) dbg_pend = 1'b0;
      if (mo == OWN_LD) begin
        mstarve = 0;
        ld_pend = 1'b0;
        $display("rand c%0d: load r%0d <= %h%s", c, bus.ld_rno, bus.ld_data, force_m ? " (forced)" : "");
      end else if (ld_pend && mstarve < SM) begin
        mstarve++;
      end
      if (exp_wr) mref[exp_rno] = exp_din;
      mack = next_ack;
      tick();
      a = $urandom_range(0, 15);
      checks++; if (rf_mem[a] !== mref[a]) begin errors++; $display("FAIL rand_mem c%0d r%0d: got %h expected %h", c, a, rf_mem[a], mref[a]); end
    end
    for (int i = 0; i < 16; i++) begin
      checks++; if (rf_mem[i] !== mref[i]) begin errors++; $display("FAIL rand_final r%0d: got %h expected %h", i, rf_mem[i], mref[i]); end
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_core_write();
    test_starve();
    test_force_core_wr();
    test_debug();
    test_back_to_back();
    test_reset_mid_clear();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
